// File: rtl/alu_operand_sequencer_if.sv
// Byte-stream input and result output handshakes for alu_operand_sequencer.
// The master drives beats in and consumes results; the slave is the sequencer.
interface alu_operand_sequencer_if #(
  parameter int N_BITS = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [N_BITS-1:0] out_data;
  logic              out_flag;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_flag
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_flag
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects opcode/A/B beats, holds them on the ALU, captures its result.
// Optional ALU_SEQ_OVF_STICKY_EN keeps an accumulated overflow bit.
module alu_operand_sequencer #(
  parameter int N_BITS = 8
) (
  input  logic                  clock,
  input  logic                  nreset,
  alu_operand_sequencer_if.slave bus,
  output logic [N_BITS-1:0]     alu_a,
  output logic [N_BITS-1:0]     alu_b,
  output logic [1:0]            alu_f,
  input  logic [N_BITS-1:0]     alu_saida,
  input  logic                  alu_flag,
  output logic                  busy,
  output logic                  ovf_sticky
);

  typedef enum logic [2:0] {
    GET_OP,
    GET_A,
    GET_B,
    EXEC,
    HOLD
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [N_BITS-1:0] a_reg;
  logic [N_BITS-1:0] b_reg;
  logic [1:0]        f_reg;
  logic [N_BITS-1:0] res_q;
  logic              flag_q;
  logic              in_rdy;
  logic              out_vld;
  logic              xfer;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) state <= GET_OP;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_rdy   = 1'b0;
    out_vld  = 1'b0;
    busy     = 1'b1;
    unique case (state)
      GET_OP: begin
        in_rdy = 1'b1;
        busy   = 1'b0;
        if (bus.in_valid) state_nx = GET_A;
      end
      GET_A: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_nx = GET_B;
      end
      GET_B: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_nx = EXEC;
      end
      EXEC: state_nx = HOLD;
      HOLD: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_nx = GET_OP;
      end
      default: state_nx = GET_OP;
    endcase
  end

  assign xfer = bus.in_valid && in_rdy;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      f_reg  <= '0;
      res_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      if (xfer && state == GET_OP) f_reg <= bus.in_data[1:0];
      if (xfer && state == GET_A)  a_reg <= bus.in_data;
      if (xfer && state == GET_B)  b_reg <= bus.in_data;
      if (state == EXEC) begin
        res_q  <= alu_saida;
        flag_q <= alu_flag;
      end
    end
  end

`ifdef ALU_SEQ_OVF_STICKY_EN
  logic ovf_q;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)                     ovf_q <= 1'b0;
    else if (state == EXEC && alu_flag) ovf_q <= 1'b1;
  end

  assign ovf_sticky = ovf_q;
`else
  assign ovf_sticky = 1'b0;
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = res_q;
  assign bus.out_flag  = flag_q;
  assign alu_a         = a_reg;
  assign alu_b         = b_reg;
  assign alu_f         = f_reg;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a behavioural ALU attached.
// ALU_SEQ_OVF_STICKY_EN selects the expected ovf_sticky behaviour.
module tb_alu_operand_sequencer;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_f;
  logic [7:0] alu_saida;
  logic       alu_flag;
  logic       busy;
  logic       ovf_sticky;
  logic       flag_stub = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];
  int hs_q[$];

`ifdef ALU_SEQ_OVF_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  alu_operand_sequencer_if #(.N_BITS(8)) bus ();

  alu_operand_sequencer #(.N_BITS(8)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_saida  (alu_saida),
    .alu_flag   (alu_flag),
    .busy       (busy),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // behavioural ALU: AND, OR, ADD, SUB; flag comes from the stub
  always_comb begin
    alu_saida = 8'h00;
    case (alu_f)
      2'd0: alu_saida = alu_a & alu_b;
      2'd1: alu_saida = alu_a | alu_b;
      2'd2: alu_saida = alu_a + alu_b;
      default: alu_saida = alu_a - alu_b;
    endcase
  end
  assign alu_flag = flag_stub;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (nreset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got=%0h want=none", bus.out_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("sb_data", {24'h0, bus.out_data}, {24'h0, e[7:0]});
        chk("sb_flag", {31'h0, bus.out_flag}, {31'h0, e[8]});
      end
      hs_q.push_back(cyc);
    end
  end

  task automatic beat(input logic [7:0] d);
    int n = 0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) chk("beat_timeout", 32'd1, 32'd0);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_op();
    int n = 0;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!bus.out_valid) chk("hs_timeout", 32'd1, 32'd0);
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hFF;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_abf", {14'h0, alu_a, alu_b, alu_f}, 32'd0);
    chk("rst_out", {23'h0, bus.out_flag, bus.out_data}, 32'd0);
    chk("rst_sticky", {31'h0, ovf_sticky}, 32'd0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    nreset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_no_xfer", {30'h0, alu_f}, 32'd0);

    // AND with latency check
    exp_q.push_back({1'b0, 8'h30});
    beat(8'h00);
    beat(8'hF0);
    beat(8'h3C);
    chk("and_f", {30'h0, alu_f}, 32'd0);
    chk("and_a", {24'h0, alu_a}, 32'hF0);
    chk("and_b", {24'h0, alu_b}, 32'h3C);
    chk("and_exec_valid", {31'h0, bus.out_valid}, 32'd0);
    @(posedge clock);
    #1;
    chk("and_lat_valid", {31'h0, bus.out_valid}, 32'd1);
    finish_op();
    chk("and_idle", {31'h0, busy}, 32'd0);

    // ADD under back-pressure, stray input offered while held
    exp_q.push_back({1'b0, 8'h90});
    beat(8'h02);
    beat(8'h70);
    beat(8'h20);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (4) begin
      @(negedge clock);
      chk("bp_valid", {31'h0, bus.out_valid}, 32'd1);
      chk("bp_data", {24'h0, bus.out_data}, 32'h90);
      chk("bp_in_ready", {31'h0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    chk("bp_a_kept", {24'h0, alu_a}, 32'h70);
    finish_op();
    chk("bp_getop", {31'h0, busy}, 32'd0);

    // flag capture and sticky behaviour
    flag_stub = 1'b1;
    exp_q.push_back({1'b1, 8'hFE});
    beat(8'h03);
    beat(8'h05);
    beat(8'h07);
    finish_op();
    flag_stub = 1'b0;
    chk("ovf_set", {31'h0, ovf_sticky}, {31'h0, STICKY_EN});
    exp_q.push_back({1'b0, 8'h0F});
    beat(8'h00);
    beat(8'hFF);
    beat(8'h0F);
    finish_op();
    chk("ovf_hold", {31'h0, ovf_sticky}, {31'h0, STICKY_EN});

    // opcode masking with gaps between beats
    exp_q.push_back({1'b0, 8'hC3});
    beat(8'hFD);
    repeat (2) @(posedge clock);
    beat(8'h81);
    repeat (3) @(posedge clock);
    #1;
    chk("gap_a", {24'h0, alu_a}, 32'h81);
    chk("gap_busy", {31'h0, busy}, 32'd1);
    beat(8'h42);
    chk("mask_f", {30'h0, alu_f}, 32'd1);
    chk("gap_b", {24'h0, alu_b}, 32'h42);
    finish_op();

    // reset after the A beat
    beat(8'h02);
    beat(8'h11);
    @(negedge clock);
    nreset = 1'b0;
    #3;
    chk("mid_rst_a", {24'h0, alu_a}, 32'd0);
    chk("mid_rst_busy", {31'h0, busy}, 32'd0);
    @(negedge clock);
    nreset = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("mid_rst_novalid", {31'h0, bus.out_valid}, 32'd0);
    end
    bus.out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h33});
    beat(8'h02);
    beat(8'h11);
    beat(8'h22);
    finish_op();

    // back-to-back streaming
    hs_q.delete();
    bus.out_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h03});
    exp_q.push_back({1'b0, 8'h11});
    beat(8'h02);
    beat(8'h01);
    beat(8'h02);
    beat(8'h01);
    beat(8'h10);
    beat(8'h01);
    begin
      int n = 0;
      while (hs_q.size() < 2 && n < 20) begin
        @(posedge clock);
        n++;
      end
    end
    bus.out_ready = 1'b0;
    chk("b2b_count", hs_q.size(), 32'd2);
    if (hs_q.size() == 2)
      chk("b2b_period", hs_q[1] - hs_q[0], 32'd5);

    repeat (2) @(posedge clock);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
